// File: rtl/even_count_monitor.sv
// Passive checker for a 4-bit even up/down counter: recovers the counting
// direction from the sampled bus and flags every transition the counter cannot make.
module even_count_monitor (
    input  logic       clock,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       locked,
    output logic       up,
    output logic       down,
    output logic       err,
    output logic       rev,
    output logic [3:0] errcnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] prev;
    logic [3:0] prev_next;
    logic [3:0] errcnt_next;
    logic       up_next;
    logic       down_next;
    logic       err_next;
    logic       rev_next;

    logic [3:0] sample;
    logic       odd;
    logic       step_up;
    logic       step_down;
    logic       legal;

    assign sample = {A, B, C, D};
    assign odd    = D;

    // Comparisons are 4 bits wide, so 14->0 and 0->14 wrap naturally.
    assign step_up   = (sample == prev + 4'd2);
    assign step_down = (sample == prev - 4'd2);
    assign legal     = !odd && (step_up || step_down);

    always_comb begin
        state_next = state;
        prev_next  = prev;
        up_next    = up;
        down_next  = down;
        err_next   = 1'b0;
        rev_next   = 1'b0;

        case (state)
            IDLE: begin
                if (odd) begin
                    err_next = 1'b1;
                end else begin
                    prev_next  = sample;
                    state_next = SYNC;
                end
            end

            SYNC: begin
                if (odd) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (legal) begin
                    prev_next  = sample;
                    up_next    = step_up;
                    down_next  = step_down;
                    state_next = LOCK;
                end else begin
                    err_next  = 1'b1;
                    prev_next = sample;
                end
            end

            LOCK: begin
                if (odd) begin
                    err_next   = 1'b1;
                    up_next    = 1'b0;
                    down_next  = 1'b0;
                    state_next = IDLE;
                end else if (legal) begin
                    prev_next = sample;
                    up_next   = step_up;
                    down_next = step_down;
                    // While locked exactly one of up/down is set, so comparing
                    // against the old up flag detects any reversal.
                    rev_next  = (step_up != up);
                end else begin
                    err_next   = 1'b1;
                    up_next    = 1'b0;
                    down_next  = 1'b0;
                    prev_next  = sample;
                    state_next = SYNC;
                end
            end

            default: begin
                up_next    = 1'b0;
                down_next  = 1'b0;
                state_next = IDLE;
            end
        endcase

        errcnt_next = errcnt;
        if (err_next && (errcnt != 4'hF)) begin
            errcnt_next = errcnt + 4'd1;
        end
    end

    // locked is registered from the next state so it never lags the FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            prev   <= 4'd0;
            locked <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;
            err    <= 1'b0;
            rev    <= 1'b0;
            errcnt <= 4'd0;
        end else begin
            state  <= state_next;
            prev   <= prev_next;
            locked <= (state_next == LOCK);
            up     <= up_next;
            down   <= down_next;
            err    <= err_next;
            rev    <= rev_next;
            errcnt <= errcnt_next;
        end
    end

endmodule
